// File: rtl/apb_regs_pkg.sv
// apb_regs_pkg: register offsets, field positions and FSM state type for the APB register slave.
package apb_regs_pkg;
    localparam int OFS_CTRL   = 'h20;
    localparam int OFS_STATUS = 'h24;
    localparam int OFS_ID     = 'h28;
    localparam int MAX_REGS   = 8;
    localparam int WAIT_W     = 4;
    localparam int ERR_CNT_W  = 16;
    localparam int PROTO_BIT  = 16;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/apb_regs_decode.sv
// apb_regs_decode: address decode (addr, write -> scr_idx, scr_hit, ctrl_hit, status_hit, id_hit, err).
module apb_regs_decode
    import apb_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_REGS   = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write,
    output logic [2:0]            scr_idx,
    output logic                  scr_hit,
    output logic                  ctrl_hit,
    output logic                  status_hit,
    output logic                  id_hit,
    output logic                  err
);
    logic aligned;
    always_comb begin
        aligned    = addr[1:0] == 2'b00;
        scr_idx    = addr[4:2];
        scr_hit    = aligned && addr < ADDR_WIDTH'(4 * NUM_REGS);
        ctrl_hit   = addr == ADDR_WIDTH'(OFS_CTRL);
        status_hit = addr == ADDR_WIDTH'(OFS_STATUS);
        id_hit     = addr == ADDR_WIDTH'(OFS_ID);
        // misaligned addresses miss every exact compare and so fall into "unmapped"
        err        = !(scr_hit || ctrl_hit || status_hit || id_hit) || (write && (status_hit || id_hit));
    end
endmodule

// File: rtl/apb_regs_slave.sv
// apb_regs_slave: APB3 completer with scratch/CTRL/STATUS/ID registers, programmable wait states and PSLVERR.
// Ports: HCLK/HRESET (sync, active-high); PADDR, PWDATA, PWRITE, PSEL, PENABLE in; PRDATA, PREADY, PSLVERR out (registered).
module apb_regs_slave
    import apb_regs_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          NUM_REGS   = 8,
    parameter logic [31:0] ID_VALUE   = 32'h5A5A_0001
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    input  logic                  PWRITE,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);
    state_t                 state, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, dec_addr;
    logic                   write_q, dec_write, setup;
    logic [31:0]            wdata_q, rd_val, rdata_d;
    logic [WAIT_W-1:0]      cnt, wait_cfg;
    logic [31:0]            scratch [MAX_REGS];
    logic [ERR_CNT_W-1:0]   err_cnt;
    logic                   proto_err;
    logic [2:0]             scr_idx;
    logic                   scr_hit, ctrl_hit, status_hit, id_hit, err;

    assign setup = PSEL && !PENABLE;
    // In IDLE the live bus is decoded so a zero-wait response can be registered on the setup edge.
    assign dec_addr  = state == IDLE ? PADDR : addr_q;
    assign dec_write = state == IDLE ? PWRITE : write_q;

    apb_regs_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_decode (
        .addr       (dec_addr),
        .write      (dec_write),
        .scr_idx    (scr_idx),
        .scr_hit    (scr_hit),
        .ctrl_hit   (ctrl_hit),
        .status_hit (status_hit),
        .id_hit     (id_hit),
        .err        (err)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        if (state == IDLE && setup) state_d = wait_cfg != '0 ? WAIT : RESP;
        else if (state == WAIT) state_d = !PSEL ? IDLE : (cnt == WAIT_W'(1) ? RESP : WAIT);
    end

    always_comb begin
        rd_val = scr_hit    ? scratch[scr_idx] :
                 ctrl_hit   ? {{(32-WAIT_W){1'b0}}, wait_cfg} :
                 status_hit ? {{(31-PROTO_BIT){1'b0}}, proto_err, err_cnt} :
                 id_hit     ? ID_VALUE : '0;
        rdata_d = (state_d == RESP && !err && !dec_write) ? rd_val : '0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            PRDATA    <= '0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            cnt       <= '0;
            wait_cfg  <= '0;
            err_cnt   <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < MAX_REGS; i++) scratch[i] <= '0;
        end else begin
            PRDATA  <= rdata_d;
            PREADY  <= state_d == RESP;
            PSLVERR <= state_d == RESP && err;
            if (state == IDLE && setup) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                cnt     <= wait_cfg;
            end else if (state == WAIT) cnt <= cnt - WAIT_W'(1);
            if (state == IDLE && PSEL && PENABLE) proto_err <= 1'b1;
            // commit on the response cycle; PSLVERR already holds this transfer's error
            if (state == RESP) begin
                if (PSLVERR) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
                end else if (write_q) begin
                    if (scr_hit) scratch[scr_idx] <= wdata_q;
                    if (ctrl_hit) wait_cfg <= wdata_q[WAIT_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_regs_slave.sv
// tb_apb_regs_slave: randomized APB bench with a behavioural register-map model and per-cycle output checking.
module tb_apb_regs_slave;
    localparam int NREGS = 6;
    localparam logic [31:0] ID = 32'h5A5A_0001;

    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0, PRDATA;
    logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PREADY, PSLVERR;

    apb_regs_slave #(.ADDR_WIDTH(12), .NUM_REGS(NREGS), .ID_VALUE(ID)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0, errors = 0;
    logic [31:0] m_scr [8];
    logic [3:0]  m_wait;
    logic [15:0] m_err;
    logic        m_proto;

    logic        chk_en = 1'b0, active = 1'b0, exp_err = 1'b0, got_err;
    int          acc_k = 0, exp_wt = 0, got_k;
    logic [31:0] exp_rdata = '0, got_rdata;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_scr[i] = '0;
        m_wait = '0;
        m_err = '0;
        m_proto = 1'b0;
    endfunction

    function automatic void model_expect(input logic [11:0] a, input logic w, output logic e, output logic [31:0] r);
        int ia = int'(a);
        e = 1'b0;
        r = '0;
        if (a[1:0] != 2'b00) e = 1'b1;
        else if (ia < 4 * NREGS) r = m_scr[ia / 4];
        else if (ia == 'h20) r = {28'b0, m_wait};
        else if (ia == 'h24) begin r = {15'b0, m_proto, m_err}; e = w; end
        else if (ia == 'h28) begin r = ID; e = w; end
        else e = 1'b1;
        if (e || w) r = '0;
    endfunction

    function automatic void model_commit(input logic [11:0] a, input logic w, input logic [31:0] d, input logic e);
        int ia = int'(a);
        if (e) begin
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end else if (w) begin
            if (ia < 4 * NREGS) m_scr[ia / 4] = d;
            else if (ia == 'h20) m_wait = d[3:0];
        end
    endfunction

    // Runs one transfer starting at posedge+1; rst_at>0 asserts HRESET during that access cycle.
    task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d, input int rst_at);
        logic e;
        logic [31:0] r;
        int wt;
        model_expect(a, w, e, r);
        wt = int'(m_wait);
        got_k = 0;
        got_rdata = 32'hxxxx_xxxx;
        got_err = 1'bx;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        exp_wt = wt; exp_err = e; exp_rdata = r; acc_k = 1; active = 1'b1;
        for (int k = 1; k <= wt + 1; k++) begin
            if (k == rst_at) HRESET = 1'b1;
            @(posedge HCLK); #1;
            if (k == rst_at) begin
                HRESET = 1'b0; active = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
                model_reset();
                return;
            end
            acc_k = k + 1;
        end
        active = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        model_commit(a, w, d, e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge HCLK); #1; end
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            logic exp_rdy;
            exp_rdy = active && (acc_k == exp_wt + 1);
            check("pready", 32'(PREADY), 32'(exp_rdy));
            if (exp_rdy) begin
                check("pslverr", 32'(PSLVERR), 32'(exp_err));
                check("prdata", PRDATA, exp_rdata);
                got_k = acc_k;
                got_rdata = PRDATA;
                got_err = PSLVERR;
            end else check("prdata_idle", PRDATA, 32'h0);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pready", 32'(PREADY), 32'h0);
        check("rst_pslverr", 32'(PSLVERR), 32'h0);
        chk_en = 1'b1;
        @(posedge HCLK); #1;

        xfer(12'h000, 1'b1, 32'hFACE_DEAD, 0);
        check("w0_latency", 32'(got_k), 32'd1);
        check("w0_err", 32'(got_err), 32'h0);
        idle(1);
        xfer(12'h000, 1'b0, '0, 0);
        check("r0_data", got_rdata, 32'hFACE_DEAD);

        xfer(12'h020, 1'b1, 32'h3, 0);
        xfer(12'h028, 1'b0, '0, 0);
        check("id_latency", 32'(got_k), 32'd4);
        check("id_data", got_rdata, 32'h5A5A_0001);

        xfer(12'h028, 1'b1, 32'h1111_1111, 0);
        check("err_w_id", 32'(got_err), 32'h1);
        xfer(12'h040, 1'b0, '0, 0);
        check("err_unmapped", 32'(got_err), 32'h1);
        xfer(12'h002, 1'b1, 32'h2222_2222, 0);
        check("err_misaligned", 32'(got_err), 32'h1);
        xfer(12'h024, 1'b0, '0, 0);
        check("status_cnt3", got_rdata, 32'h0000_0003);
        xfer(12'h000, 1'b0, '0, 0);
        check("r0_unchanged", got_rdata, 32'hFACE_DEAD);

        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 12'h004; PWRITE = 1'b1;
        idle(1);
        PSEL = 1'b0; PENABLE = 1'b0;
        m_proto = 1'b1;
        idle(1);
        xfer(12'h024, 1'b0, '0, 0);
        check("status_proto", got_rdata, 32'h0001_0003);

        xfer(12'h020, 1'b1, 32'h4, 0);
        xfer(12'h004, 1'b1, 32'h1234_5678, 2);
        idle(1);
        xfer(12'h004, 1'b0, '0, 0);
        check("abort_scr1", got_rdata, 32'h0);
        xfer(12'h020, 1'b0, '0, 0);
        check("abort_ctrl", got_rdata, 32'h0);

        xfer(12'h004, 1'b1, 32'hCAFE_F00D, 0);
        xfer(12'h004, 1'b0, '0, 0);
        check("b2b_read", got_rdata, 32'hCAFE_F00D);

        for (int i = 0; i < 300; i++) begin
            int sel;
            logic [11:0] a;
            logic [31:0] d;
            logic w;
            sel = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (sel < 6) a = 12'($urandom_range(0, 11) * 4);
            else if (sel < 8) begin a = 12'h020; d = (d & 32'hFFFF_FFF0) | 32'($urandom_range(0, 3)); end
            else a = 12'($urandom);
            if (sel == 9 && i % 3 == 0) begin
                PSEL = 1'b1; PENABLE = 1'b1; PADDR = a;
                idle(1);
                PSEL = 1'b0; PENABLE = 1'b0;
                m_proto = 1'b1;
            end
            xfer(a, w, d, 0);
            idle($urandom_range(0, 2));
        end
        xfer(12'h024, 1'b0, '0, 0);
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
